change_dispenser: RTL and testbench

Change-return side of the chocolate vending machine: accepts a refund amount and drives a coin hopper with one coin code at a time, using the same 2-bit coin encoding the machine accepts. It tracks per-denomination hopper inventory and returns the largest coin first. If exact change cannot be paid from stock, it flags a shortfall. It sits between the vending controller, which requests the refund, and the hopper mechanism, which acknowledges each coin it ejects.

---
 rtl/change_dispenser.sv | 192 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Greedy change dispenser driving a coin hopper one coin at a time,
//            with per-denomination inventory. Macro CHANGE_TIMEOUT_EN adds an
//            ack timeout while a coin is offered.
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int AMT_W   = 6,
    parameter int CNT_W   = 8,
    parameter int INIT_20 = 8,
    parameter int INIT_10 = 8,
    parameter int INIT_5  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] req_amount,
    output logic [1:0]       coin,
    output logic             coin_valid,
    input  logic             coin_ack,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining,
    input  logic             refill_valid,
    input  logic [1:0]       refill_coin,
    output logic [2:0]       empty
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_OFFER  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

`ifdef CHANGE_TIMEOUT_EN
    localparam logic c_tmo_en = 1'b1;
`else
    localparam logic c_tmo_en = 1'b0;
`endif
    localparam int               c_tmo_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);

    state_t             r_state, w_state_nxt;
    logic [AMT_W-1:0]   r_rem, w_rem_nxt;
    logic [1:0]         r_coin, w_coin_nxt;
    logic               r_cv, w_cv_nxt;
    logic               r_done, w_done_nxt;
    logic               r_short, w_short_nxt;
    logic               r_ready;
    logic               w_take;
    logic               w_tmo_hit;
    logic [c_tmo_w-1:0] r_tmo;
    logic [2:0]         w_avail;
    logic [AMT_W-1:0]   w_coin_amt;

    // Inventory index 0/1/2 holds 5/10/20 coins, i.e. coin code = index + 1
    for (genvar gi = 0; gi < 3; gi++) begin : g_inv
        localparam int c_init = (gi == 2) ? INIT_20 : ((gi == 1) ? INIT_10 : INIT_5);
        logic [CNT_W-1:0] r_cnt;
        logic             w_inc;
        logic             w_dec;

        assign w_inc = refill_valid && (refill_coin == 2'(gi + 1));
        assign w_dec = w_take && (r_coin == 2'(gi + 1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= CNT_W'(c_init);
            end else if (w_inc && !w_dec) begin
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_dec && !w_inc) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end

        assign w_avail[gi] = (r_cnt != '0);
        assign empty[gi]   = (r_cnt == '0);
    end

    assign w_coin_amt = (r_coin == 2'b11) ? AMT_W'(4) :
                        (r_coin == 2'b10) ? AMT_W'(2) : AMT_W'(1);

    // Timer stays at zero outside OFFER, so every offer starts a fresh count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (c_tmo_en && (r_state == S_OFFER) && !coin_ack) begin
            r_tmo <= r_tmo + c_tmo_w'(1);
        end else begin
            r_tmo <= '0;
        end
    end

    assign w_tmo_hit = c_tmo_en && (r_state == S_OFFER) && (r_tmo == c_tmo_last);

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_coin_nxt  = r_coin;
        w_cv_nxt    = r_cv;
        w_done_nxt  = 1'b0;
        w_short_nxt = 1'b0;
        w_take      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_rem_nxt   = req_amount;
                    w_state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                if (r_rem == '0) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else if ((r_rem >= AMT_W'(4)) && w_avail[2]) begin
                    w_coin_nxt  = 2'b11;
                    w_cv_nxt    = 1'b1;
                    w_state_nxt = S_OFFER;
                end else if ((r_rem >= AMT_W'(2)) && w_avail[1]) begin
                    w_coin_nxt  = 2'b10;
                    w_cv_nxt    = 1'b1;
                    w_state_nxt = S_OFFER;
                end else if (w_avail[0]) begin
                    w_coin_nxt  = 2'b01;
                    w_cv_nxt    = 1'b1;
                    w_state_nxt = S_OFFER;
                end else begin
                    w_done_nxt  = 1'b1;
                    w_short_nxt = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_OFFER: begin
                if (coin_ack) begin
                    w_take      = 1'b1;
                    w_rem_nxt   = r_rem - w_coin_amt;
                    w_coin_nxt  = 2'b00;
                    w_cv_nxt    = 1'b0;
                    w_state_nxt = S_SELECT;
                end else if (w_tmo_hit) begin
                    w_coin_nxt  = 2'b00;
                    w_cv_nxt    = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_short_nxt = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_coin  <= 2'b00;
            r_cv    <= 1'b0;
            r_done  <= 1'b0;
            r_short <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_coin  <= w_coin_nxt;
            r_cv    <= w_cv_nxt;
            r_done  <= w_done_nxt;
            r_short <= w_short_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
        end
    end

    assign req_ready  = r_ready;
    assign coin       = r_coin;
    assign coin_valid = r_cv;
    assign done       = r_done;
    assign short      = r_short;
    assign remaining  = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser
// Purpose  : Scoreboard testbench for change_dispenser (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

    localparam int AMT_W   = 6;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 4;

    typedef struct {
        bit         is_done;
        logic [1:0] coin;
        bit         sh;
        int         rem;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [AMT_W-1:0] req_amount = '0;
    logic [1:0]       coin;
    logic             coin_valid;
    logic             coin_ack = 1'b0;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] remaining;
    logic             refill_valid = 1'b0;
    logic [1:0]       refill_coin = 2'b00;
    logic [2:0]       empty;

    int   total = 0;
    int   passed = 0;
    exp_t sb[$];
    int   hop_delay = 0;
    bit   skip_lat = 1'b0;

    change_dispenser #(
        .AMT_W   (AMT_W),
        .CNT_W   (CNT_W),
        .INIT_20 (8),
        .INIT_10 (8),
        .INIT_5  (8),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_amount   (req_amount),
        .coin         (coin),
        .coin_valid   (coin_valid),
        .coin_ack     (coin_ack),
        .done         (done),
        .short        (short),
        .remaining    (remaining),
        .refill_valid (refill_valid),
        .refill_coin  (refill_coin),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Hopper model: acks after hop_delay waiting cycles, then reverts to zero-wait
    initial begin
        int hop_w;
        hop_w = 0;
        forever begin
            @(posedge clk);
            #1;
            if (coin_valid && rst_n) begin
                if (hop_w >= hop_delay) begin
                    coin_ack  = 1'b1;
                    hop_delay = 0;
                end else begin
                    coin_ack = 1'b0;
                end
                hop_w++;
            end else begin
                coin_ack = 1'b0;
                hop_w    = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each new coin offer and each done pulse
    int         cyc = 0;
    int         last_evt = 0;
    bit         prev_cv = 1'b0;
    logic [1:0] held_coin = 2'b00;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_cv  = 1'b0;
            last_evt = cyc;
        end else begin
            cyc++;
            if (req_valid && req_ready) last_evt = cyc;
            if (coin_valid && !prev_cv) begin
                chk("sb_has_coin", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("evt_is_coin", int'(e.is_done), 0);
                    chk("coin_code", int'(coin), int'(e.coin));
                end
                chk("coin_latency", cyc - last_evt, 2);
                held_coin = coin;
            end else if (coin_valid) begin
                chk("coin_stable", int'(coin), int'(held_coin));
            end
            if (coin_valid && coin_ack) last_evt = cyc;
            if (done) begin
                chk("sb_has_done", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("evt_is_done", int'(e.is_done), 1);
                    chk("done_short", int'(short), int'(e.sh));
                    chk("done_remaining", int'(remaining), e.rem);
                end
                if (!skip_lat) chk("done_latency", cyc - last_evt, 2);
            end
            prev_cv = coin_valid;
        end
    end

    task automatic push_coins(input int n20, input int n10, input int n5);
        exp_t e;
        e.is_done = 1'b0;
        e.sh      = 1'b0;
        e.rem     = 0;
        e.coin    = 2'b11;
        for (int i = 0; i < n20; i++) sb.push_back(e);
        e.coin = 2'b10;
        for (int i = 0; i < n10; i++) sb.push_back(e);
        e.coin = 2'b01;
        for (int i = 0; i < n5; i++) sb.push_back(e);
    endtask

    task automatic push_done(input bit sh, input int rem);
        exp_t e;
        e.is_done = 1'b1;
        e.coin    = 2'b00;
        e.sh      = sh;
        e.rem     = rem;
        sb.push_back(e);
    endtask

    task automatic issue_req(input int amt, input bit refill_at_ack);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (!req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("req_ready_wait", int'(req_ready), 1);
        req_valid  = 1'b1;
        req_amount = AMT_W'(amt);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (refill_at_ack) begin
            @(posedge clk);
            #1;
            chk("refill_during_offer", int'(coin_valid), 1);
            refill_valid = 1'b1;
            refill_coin  = 2'b10;
            @(posedge clk);
            #1;
            refill_valid = 1'b0;
            refill_coin  = 2'b00;
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(done), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input int amt, input int n20, input int n10, input int n5,
                           input bit sh, input int rem, input bit refill_at_ack);
        push_coins(n20, n10, n5);
        push_done(sh, rem);
        issue_req(amt, refill_at_ack);
        wait_done("done_seen");
    endtask

    task automatic refill(input logic [1:0] code, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            refill_valid = 1'b1;
            refill_coin  = code;
        end
        @(posedge clk);
        #1;
        refill_valid = 1'b0;
        refill_coin  = 2'b00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_coin", int'(coin), 0);
        chk("rst_coin_valid", int'(coin_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_short", int'(short), 0);
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_empty", int'(empty), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", int'(req_ready), 1);

        // Full inventory, greedy 20+10+5
        run_req(7, 1, 1, 1, 1'b0, 0, 1'b0);
        chk("empty_t1", int'(empty), 0);
        // Drain the 20s, then a 20-unit request must use two 10s
        run_req(28, 7, 0, 0, 1'b0, 0, 1'b0);
        chk("empty_no20", int'(empty), 3'b100);
        run_req(4, 0, 2, 0, 1'b0, 0, 1'b0);
        chk("empty_t2", int'(empty), 3'b100);
        // Refill 10 in the ack cycle of a 10: count stays 5, proven by draining
        run_req(2, 0, 1, 0, 1'b0, 0, 1'b1);
        run_req(10, 0, 5, 0, 1'b0, 0, 1'b0);
        chk("empty_no10", int'(empty), 3'b110);
        run_req(6, 0, 0, 6, 1'b0, 0, 1'b0);
        chk("empty_one5", int'(empty), 3'b110);
        // Only one 5 left: short with 2 unpaid
        run_req(3, 0, 0, 1, 1'b1, 2, 1'b0);
        chk("empty_all", int'(empty), 3'b111);
        run_req(0, 0, 0, 0, 1'b0, 0, 1'b0);
        chk("empty_zero_req", int'(empty), 3'b111);

        // Refills (00 ignored), then delayed ack on the first coin
        refill(2'b11, 2);
        refill(2'b10, 1);
        refill(2'b01, 1);
        refill(2'b00, 3);
        chk("empty_refilled", int'(empty), 0);
        hop_delay = 5;
        run_req(7, 1, 1, 1, 1'b0, 0, 1'b0);
        chk("empty_after_delay", int'(empty), 3'b011);
        run_req(6, 1, 0, 0, 1'b1, 2, 1'b0);
        chk("empty_short20", int'(empty), 3'b111);

        // Saturation: 260 refills of 5 leave exactly 255
        refill(2'b01, 260);
        chk("empty_sat", int'(empty), 3'b110);
        for (int k = 0; k < 4; k++) run_req(63, 0, 0, 63, 1'b0, 0, 1'b0);
        run_req(5, 0, 0, 3, 1'b1, 2, 1'b0);
        chk("empty_sat_drained", int'(empty), 3'b111);

        // Asynchronous reset while a coin is being offered
        refill(2'b11, 1);
        hop_delay = 1000;
        push_coins(1, 0, 0);
        issue_req(4, 1'b0);
        n = 0;
        while (!coin_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rm_offering", int'(coin_valid), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rm_coin_valid", int'(coin_valid), 0);
        chk("rm_coin", int'(coin), 0);
        chk("rm_remaining", int'(remaining), 0);
        chk("rm_done", int'(done), 0);
        chk("rm_short", int'(short), 0);
        chk("rm_empty_reload", int'(empty), 0);
        hop_delay = 0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_req(7, 1, 1, 1, 1'b0, 0, 1'b0);
        chk("empty_after_rm", int'(empty), 0);

`ifdef CHANGE_TIMEOUT_EN
        hop_delay = 1000;
        skip_lat  = 1'b1;
        push_coins(0, 1, 0);
        push_done(1'b1, 2);
        issue_req(2, 1'b0);
        n = 0;
        while (!coin_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (coin_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", n, TIMEOUT);
        wait_done("tmo_done_seen");
        skip_lat  = 1'b0;
        hop_delay = 0;
`endif

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
